// File: rtl/vx_lsu_req_batcher_pkg.sv
// rtl/vx_lsu_req_batcher_pkg.sv - shared constants and sizing helpers for the LSU request batcher
package vx_lsu_req_batcher_pkg;

    // FSM state encoding
    typedef logic [0:0] lsu_state_t;

    localparam lsu_state_t ST_IDLE = 1'b0;
    localparam lsu_state_t ST_SEND = 1'b1;

    // Number of lane-sized batches a request is split into
    function automatic int calc_num_batches(input int num_threads, input int num_lanes);
        return num_threads / num_lanes;
    endfunction

    // Batch index width; a single batch still needs a one-bit index port
    function automatic int calc_batch_w(input int num_batches);
        return (num_batches > 1) ? $clog2(num_batches) : 1;
    endfunction

endpackage

// File: rtl/vx_lsu_req_batcher_batch_find.sv
// rtl/vx_lsu_req_batcher_batch_find.sv - priority encoder picking the next non-empty batch
module vx_lsu_req_batcher_batch_find
    import vx_lsu_req_batcher_pkg::*;
#(
    parameter int NUM_BATCHES = 2,
    parameter int NUM_LANES   = 2,
    parameter int BATCH_W     = 1
) (
    input  logic [NUM_BATCHES*NUM_LANES-1:0] pmask,
    output logic                             has_any,
    output logic [BATCH_W-1:0]               idx,
    output logic                             last
);

    logic [NUM_BATCHES-1:0] nz;

    // One bit per batch: does this batch still hold any pending thread
    always_comb begin
        nz = '0;
        for (int b = 0; b < NUM_BATCHES; b++) begin
            nz[b] = |pmask[b*NUM_LANES +: NUM_LANES];
        end
    end

    // Lowest non-empty batch wins; it is the last one if nothing above it is pending
    always_comb begin
        logic found;
        found   = 1'b0;
        has_any = |nz;
        idx     = '0;
        last    = 1'b1;
        for (int b = 0; b < NUM_BATCHES; b++) begin
            if (nz[b]) begin
                if (!found) begin
                    found = 1'b1;
                    idx   = BATCH_W'(b);
                end else begin
                    last = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/vx_lsu_req_batcher.sv
// rtl/vx_lsu_req_batcher.sv - splits a multi-thread LSU request into lane-sized batches
module vx_lsu_req_batcher
    import vx_lsu_req_batcher_pkg::*;
#(
    parameter int NUM_THREADS  = 4,
    parameter int NUM_LANES    = 2,
    parameter int XLEN         = 32,
    parameter int UUID_W       = 44,
    parameter int NW_W         = 2,
    parameter int OP_W         = 4,
    parameter int NR_W         = 6,
    localparam int NUM_BATCHES = calc_num_batches(NUM_THREADS, NUM_LANES),
    localparam int BATCH_W     = calc_batch_w(NUM_BATCHES)
) (
    input  logic                                clk,
    input  logic                                reset,

    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [UUID_W-1:0]                   in_uuid,
    input  logic [NW_W-1:0]                     in_wid,
    input  logic [XLEN-1:0]                     in_PC,
    input  logic [OP_W-1:0]                     in_op_type,
    input  logic [NR_W-1:0]                     in_rd,
    input  logic                                in_wb,
    input  logic [NUM_THREADS-1:0]              in_tmask,
    input  logic [NUM_THREADS-1:0][XLEN-1:0]    in_store_data,
    input  logic [NUM_THREADS-1:0][XLEN-1:0]    in_base_addr,
    input  logic [XLEN-1:0]                     in_offset,

    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [UUID_W-1:0]                   out_uuid,
    output logic [NW_W-1:0]                     out_wid,
    output logic [XLEN-1:0]                     out_PC,
    output logic [OP_W-1:0]                     out_op_type,
    output logic [NR_W-1:0]                     out_rd,
    output logic                                out_wb,
    output logic [NUM_LANES-1:0]                out_tmask,
    output logic [NUM_LANES-1:0][XLEN-1:0]      out_addr,
    output logic [NUM_LANES-1:0][XLEN-1:0]      out_store_data,
    output logic [BATCH_W-1:0]                  out_batch_idx,
    output logic                                out_sop,
    output logic                                out_eop
);

    if ((NUM_THREADS % NUM_LANES) != 0) begin : g_bad_lanes
        $error("NUM_LANES must divide NUM_THREADS");
    end

    // Control state
    lsu_state_t                          state_q, state_d;
    logic [NUM_THREADS-1:0]              pmask_q, pmask_d;
    logic                                sop_q, sop_d;

    // Registered request (no reset needed)
    logic [UUID_W-1:0]                   uuid_q, uuid_d;
    logic [NW_W-1:0]                     wid_q, wid_d;
    logic [XLEN-1:0]                     pc_q, pc_d;
    logic [OP_W-1:0]                     op_type_q, op_type_d;
    logic [NR_W-1:0]                     rd_q, rd_d;
    logic                                wb_q, wb_d;
    logic [NUM_THREADS-1:0][XLEN-1:0]    data_q, data_d;
    logic [NUM_THREADS-1:0][XLEN-1:0]    base_q, base_d;
    logic [XLEN-1:0]                     offset_q, offset_d;

    logic                                fnd_any;
    logic [BATCH_W-1:0]                  fnd_idx;
    logic                                fnd_last;
    logic                                out_fire;
    logic                                in_fire;
    logic                                capture;

    vx_lsu_req_batcher_batch_find #(
        .NUM_BATCHES (NUM_BATCHES),
        .NUM_LANES   (NUM_LANES),
        .BATCH_W     (BATCH_W)
    ) u_batch_find (
        .pmask   (pmask_q),
        .has_any (fnd_any),
        .idx     (fnd_idx),
        .last    (fnd_last)
    );

    // Handshakes; the eop handshake doubles as an acceptance slot for the next request
    always_comb begin
        out_valid = (state_q == ST_SEND) && fnd_any && !reset;
        out_fire  = out_valid && out_ready;
        in_ready  = !reset && ((state_q == ST_IDLE) || (out_fire && fnd_last));
        in_fire   = in_valid && in_ready;
        capture   = in_fire && (|in_tmask);
    end

    // Next-state: retire the emitted batch, then let a newly accepted request override
    always_comb begin
        state_d = state_q;
        pmask_d = pmask_q;
        sop_d   = sop_q;
        if (out_fire) begin
            sop_d = 1'b0;
            for (int b = 0; b < NUM_BATCHES; b++) begin
                if (fnd_idx == BATCH_W'(b)) begin
                    for (int i = 0; i < NUM_LANES; i++) begin
                        pmask_d[b*NUM_LANES + i] = 1'b0;
                    end
                end
            end
            if (fnd_last) begin
                state_d = ST_IDLE;
            end
        end
        if (in_fire) begin
            pmask_d = in_tmask;
            sop_d   = 1'b1;
            state_d = (|in_tmask) ? ST_SEND : ST_IDLE;
        end
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pmask_q <= '0;
            sop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pmask_q <= pmask_d;
            sop_q   <= sop_d;
        end
    end

    // Request capture mux; an all-empty request is dropped and leaves the registers alone
    always_comb begin
        uuid_d    = capture ? in_uuid       : uuid_q;
        wid_d     = capture ? in_wid        : wid_q;
        pc_d      = capture ? in_PC         : pc_q;
        op_type_d = capture ? in_op_type    : op_type_q;
        rd_d      = capture ? in_rd         : rd_q;
        wb_d      = capture ? in_wb         : wb_q;
        data_d    = capture ? in_store_data : data_q;
        base_d    = capture ? in_base_addr  : base_q;
        offset_d  = capture ? in_offset     : offset_q;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        uuid_q    <= uuid_d;
        wid_q     <= wid_d;
        pc_q      <= pc_d;
        op_type_q <= op_type_d;
        rd_q      <= rd_d;
        wb_q      <= wb_d;
        data_q    <= data_d;
        base_q    <= base_d;
        offset_q  <= offset_d;
    end

    // Lane select for the current batch; address add wraps at XLEN
    always_comb begin
        out_tmask      = '0;
        out_addr       = '0;
        out_store_data = '0;
        for (int b = 0; b < NUM_BATCHES; b++) begin
            if (fnd_idx == BATCH_W'(b)) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    out_tmask[i]      = pmask_q[b*NUM_LANES + i];
                    out_addr[i]       = base_q[b*NUM_LANES + i] + offset_q;
                    out_store_data[i] = data_q[b*NUM_LANES + i];
                end
            end
        end
    end

    assign out_uuid      = uuid_q;
    assign out_wid       = wid_q;
    assign out_PC        = pc_q;
    assign out_op_type   = op_type_q;
    assign out_rd        = rd_q;
    assign out_wb        = wb_q;
    assign out_batch_idx = fnd_idx;
    assign out_sop       = sop_q;
    assign out_eop       = fnd_last;

endmodule

// File: tb/tb_vx_lsu_req_batcher.sv
// tb/tb_vx_lsu_req_batcher.sv - self-checking bench for vx_lsu_req_batcher
module tb_vx_lsu_req_batcher;

    typedef struct {
        logic [43:0]      uuid;
        logic [1:0]       wid;
        logic [31:0]      pc;
        logic [3:0]       op;
        logic [5:0]       rd;
        logic             wb;
        logic [3:0]       tmask;
        logic [3:0][31:0] base;
        logic [3:0][31:0] data;
        logic [31:0]      offset;
    } req_t;

    typedef struct {
        logic [0:0]       idx;
        logic [1:0]       tmask;
        logic [1:0][31:0] addr;
        logic [1:0][31:0] data;
        logic             sop;
        logic             eop;
        logic [88:0]      tags;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [43:0]      in_uuid;
    logic [1:0]       in_wid;
    logic [31:0]      in_PC;
    logic [3:0]       in_op_type;
    logic [5:0]       in_rd;
    logic             in_wb;
    logic [3:0]       in_tmask;
    logic [3:0][31:0] in_store_data;
    logic [3:0][31:0] in_base_addr;
    logic [31:0]      in_offset;
    logic             out_valid;
    logic             out_ready;
    logic [43:0]      out_uuid;
    logic [1:0]       out_wid;
    logic [31:0]      out_PC;
    logic [3:0]       out_op_type;
    logic [5:0]       out_rd;
    logic             out_wb;
    logic [1:0]       out_tmask;
    logic [1:0][31:0] out_addr;
    logic [1:0][31:0] out_store_data;
    logic [0:0]       out_batch_idx;
    logic             out_sop;
    logic             out_eop;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    vx_lsu_req_batcher dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_uuid        (in_uuid),
        .in_wid         (in_wid),
        .in_PC          (in_PC),
        .in_op_type     (in_op_type),
        .in_rd          (in_rd),
        .in_wb          (in_wb),
        .in_tmask       (in_tmask),
        .in_store_data  (in_store_data),
        .in_base_addr   (in_base_addr),
        .in_offset      (in_offset),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_uuid       (out_uuid),
        .out_wid        (out_wid),
        .out_PC         (out_PC),
        .out_op_type    (out_op_type),
        .out_rd         (out_rd),
        .out_wb         (out_wb),
        .out_tmask      (out_tmask),
        .out_addr       (out_addr),
        .out_store_data (out_store_data),
        .out_batch_idx  (out_batch_idx),
        .out_sop        (out_sop),
        .out_eop        (out_eop)
    );

    function automatic req_t mk_req(input logic [3:0] tmask, input logic [31:0] b0, input logic [31:0] b1,
                                    input logic [31:0] b2, input logic [31:0] b3, input logic [31:0] offset);
        req_t r;
        r.uuid    = {12'($urandom), $urandom};
        r.wid     = 2'($urandom);
        r.pc      = $urandom;
        r.op      = 4'($urandom);
        r.rd      = 6'($urandom);
        r.wb      = 1'($urandom);
        r.tmask   = tmask;
        r.base    = {b3, b2, b1, b0};
        r.data    = {$urandom, $urandom, $urandom, $urandom};
        r.offset  = offset;
        return r;
    endfunction

    function automatic logic [88:0] tags_of(input req_t r);
        return {r.uuid, r.wid, r.pc, r.op, r.rd, r.wb};
    endfunction

    // Reference: list the non-empty lane groups in order, flag first and last
    function automatic void model_push(input req_t r);
        int   first = -1;
        int   lastb = -1;
        exp_t e;
        for (int b = 0; b < 2; b++) begin
            if (r.tmask[2*b +: 2] != 2'b00) begin
                if (first < 0) first = b;
                lastb = b;
            end
        end
        for (int b = 0; b < 2; b++) begin
            if (r.tmask[2*b +: 2] != 2'b00) begin
                e.idx   = 1'(b);
                e.tmask = r.tmask[2*b +: 2];
                for (int i = 0; i < 2; i++) begin
                    e.addr[i] = r.base[2*b + i] + r.offset;
                    e.data[i] = r.data[2*b + i];
                end
                e.sop  = (b == first);
                e.eop  = (b == lastb);
                e.tags = tags_of(r);
                exp_q.push_back(e);
            end
        end
    endfunction

    task automatic drive_req(input req_t r);
        in_uuid       = r.uuid;
        in_wid        = r.wid;
        in_PC         = r.pc;
        in_op_type    = r.op;
        in_rd         = r.rd;
        in_wb         = r.wb;
        in_tmask      = r.tmask;
        in_base_addr  = r.base;
        in_store_data = r.data;
        in_offset     = r.offset;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_tests++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        @(negedge clk); reset = 1'b0; #1;
        n_tests++;
        if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL reset_idle: got rdy/vld %b expected 10", {in_ready, out_valid}); end
    endtask

    task automatic test_two_batches();
        req_t r;
        r = mk_req(4'b1111, 32'h100, 32'h200, 32'h300, 32'h400, 32'h4);
        @(negedge clk); drive_req(r); in_valid = 1'b1; out_ready = 1'b1; #1;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL two_accept: got in_ready %b expected 1", in_ready); end
        @(negedge clk); in_valid = 1'b0; #1;
        n_tests++;
        if ({out_valid, out_batch_idx, out_tmask, out_sop, out_eop} !== 6'b1_0_11_1_0) begin
            n_fail++; $display("FAIL two_b0_ctrl: got %b expected 101110", {out_valid, out_batch_idx, out_tmask, out_sop, out_eop});
        end
        n_tests++;
        if (out_addr !== {32'h204, 32'h104}) begin n_fail++; $display("FAIL two_b0_addr: got %h expected 0000020400000104", out_addr); end
        n_tests++;
        if (out_store_data !== {r.data[1], r.data[0]} || {out_uuid, out_wid, out_PC, out_op_type, out_rd, out_wb} !== tags_of(r)) begin
            n_fail++; $display("FAIL two_b0_data_tags: got %h expected %h", out_store_data, {r.data[1], r.data[0]});
        end
        @(negedge clk); #1;
        n_tests++;
        if ({out_valid, out_batch_idx, out_tmask, out_sop, out_eop} !== 6'b1_1_11_0_1) begin
            n_fail++; $display("FAIL two_b1_ctrl: got %b expected 111101", {out_valid, out_batch_idx, out_tmask, out_sop, out_eop});
        end
        n_tests++;
        if (out_addr !== {32'h404, 32'h304}) begin n_fail++; $display("FAIL two_b1_addr: got %h expected 0000040400000304", out_addr); end
        @(negedge clk); #1;
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL two_done: got vld/rdy %b expected 01", {out_valid, in_ready}); end
    endtask

    task automatic test_single_batch();
        req_t r;
        r = mk_req(4'b1100, 32'h10, 32'h20, 32'h1000, 32'h2000, 32'h8);
        @(negedge clk); drive_req(r); in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk); in_valid = 1'b0; #1;
        n_tests++;
        if ({out_valid, out_batch_idx, out_tmask, out_sop, out_eop} !== 6'b1_1_11_1_1) begin
            n_fail++; $display("FAIL single_ctrl: got %b expected 111111", {out_valid, out_batch_idx, out_tmask, out_sop, out_eop});
        end
        n_tests++;
        if (out_addr !== {32'h2008, 32'h1008}) begin n_fail++; $display("FAIL single_addr: got %h expected 0000200800001008", out_addr); end
        @(negedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_done: got out_valid %b expected 0", out_valid); end
    endtask

    task automatic test_empty_mask();
        req_t r;
        r = mk_req(4'b0000, 32'h1, 32'h2, 32'h3, 32'h4, 32'h0);
        @(negedge clk); drive_req(r); in_valid = 1'b1; out_ready = 1'b1; #1;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL empty_accept: got in_ready %b expected 1", in_ready); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); in_valid = 1'b0; #1;
            n_tests++;
            if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL empty_idle%0d: got vld/rdy %b expected 01", k, {out_valid, in_ready}); end
        end
    endtask

    task automatic test_stall_wrap();
        req_t r;
        r = mk_req(4'b1111, 32'hFFFF_FFFC, 32'h10, 32'h20, 32'h30, 32'h8);
        @(negedge clk); drive_req(r); in_valid = 1'b1; out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); in_valid = 1'b0;
            if (k == 3) out_ready = 1'b1;
            #1;
            n_tests++;
            if ({out_valid, out_batch_idx, out_tmask, out_sop, out_eop} !== 6'b1_0_11_1_0 ||
                out_addr !== {32'h18, 32'h4} || out_store_data !== {r.data[1], r.data[0]}) begin
                n_fail++; $display("FAIL stall_hold%0d: got ctrl %b addr %h expected 101110 addr 0000001800000004",
                                   k, {out_valid, out_batch_idx, out_tmask, out_sop, out_eop}, out_addr);
            end
        end
        @(negedge clk); #1;
        n_tests++;
        if ({out_valid, out_batch_idx, out_eop} !== 3'b111 || out_addr !== {32'h38, 32'h28}) begin
            n_fail++; $display("FAIL stall_b1: got vld/idx/eop %b addr %h expected 111 addr 0000003800000028", {out_valid, out_batch_idx, out_eop}, out_addr);
        end
        @(negedge clk); #1;
    endtask

    task automatic test_back_to_back();
        req_t ra, rb;
        logic [31:0] exp_a [4];
        ra = mk_req(4'b1111, 32'h1000, 32'h1100, 32'h1200, 32'h1300, 32'h0);
        rb = mk_req(4'b1111, 32'h2000, 32'h2100, 32'h2200, 32'h2300, 32'h1);
        exp_a = '{32'h1100, 32'h1300, 32'h2101, 32'h2301};
        @(negedge clk); drive_req(ra); in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk); drive_req(rb);
        for (int k = 0; k < 4; k++) begin
            if (k == 2) in_valid = 1'b0;
            #1;
            n_tests++;
            if ({out_valid, out_batch_idx, out_sop, out_eop} !== {1'b1, 1'(k % 2), (k % 2) == 0, (k % 2) == 1} ||
                out_addr[1] !== exp_a[k] || in_ready !== ((k % 2) == 1)) begin
                n_fail++; $display("FAIL b2b_%0d: got vld/idx/sop/eop %b lane1 %h in_ready %b expected idx %0d lane1 %h",
                                   k, {out_valid, out_batch_idx, out_sop, out_eop}, out_addr[1], in_ready, k % 2, exp_a[k]);
            end
            @(negedge clk);
        end
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_done: got out_valid %b expected 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        req_t ra, rb;
        ra = mk_req(4'b1111, $urandom, $urandom, $urandom, $urandom, $urandom);
        rb = mk_req(4'b0110, 32'h500, 32'h600, 32'h700, 32'h800, 32'h10);
        @(negedge clk); drive_req(ra); in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk); in_valid = 1'b0; #1;
        n_tests++;
        if ({out_valid, out_sop} !== 2'b11) begin n_fail++; $display("FAIL rmid_b0: got vld/sop %b expected 11", {out_valid, out_sop}); end
        @(negedge clk); reset = 1'b1; #1;
        n_tests++;
        if ({out_valid, in_ready} !== 2'b00) begin n_fail++; $display("FAIL rmid_in_reset: got vld/rdy %b expected 00", {out_valid, in_ready}); end
        @(negedge clk); reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++;
            if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL rmid_quiet%0d: got vld/rdy %b expected 01", k, {out_valid, in_ready}); end
            @(negedge clk);
        end
        drive_req(rb); in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0; #1;
        n_tests++;
        if ({out_valid, out_batch_idx, out_tmask, out_sop, out_eop} !== 6'b1_0_10_1_0 || out_addr[1] !== 32'h610) begin
            n_fail++; $display("FAIL rmid_new_b0: got %b lane1 %h expected 101010 lane1 00000610", {out_valid, out_batch_idx, out_tmask, out_sop, out_eop}, out_addr[1]);
        end
        @(negedge clk); #1;
        n_tests++;
        if ({out_valid, out_batch_idx, out_tmask, out_sop, out_eop} !== 6'b1_1_01_0_1 || out_addr[0] !== 32'h710) begin
            n_fail++; $display("FAIL rmid_new_b1: got %b lane0 %h expected 110101 lane0 00000710", {out_valid, out_batch_idx, out_tmask, out_sop, out_eop}, out_addr[0]);
        end
        @(negedge clk); #1;
    endtask

    task automatic test_random(input int nreq);
        req_t reqs[$];
        req_t r;
        int   sent = 0;
        int   cyc  = 0;
        logic exp_ready;
        exp_t e;
        for (int n = 0; n < nreq; n++) begin
            r = mk_req(4'($urandom), $urandom, $urandom, $urandom, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : $urandom,
                       ($urandom_range(0, 1) == 0) ? 32'h40 : $urandom);
            if ($urandom_range(0, 7) == 0) r.tmask = 4'b0000;
            reqs.push_back(r);
        end
        exp_q.delete();
        while ((sent < nreq || exp_q.size() != 0) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            in_valid  = (sent < nreq) && ($urandom_range(0, 3) != 0);
            if (sent < nreq) drive_req(reqs[sent]);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_ready = (exp_q.size() == 0) || (exp_q[0].eop && out_ready);
            n_tests++;
            if (out_valid !== (exp_q.size() != 0)) begin
                n_fail++; $display("FAIL rand_valid cyc%0d: got %b expected %b", cyc, out_valid, exp_q.size() != 0);
            end
            n_tests++;
            if (in_ready !== exp_ready) begin
                n_fail++; $display("FAIL rand_in_ready cyc%0d: got %b expected %b", cyc, in_ready, exp_ready);
            end
            if (exp_q.size() != 0) begin
                e = exp_q[0];
                n_tests++;
                if ({out_batch_idx, out_tmask, out_sop, out_eop} !== {e.idx, e.tmask, e.sop, e.eop} ||
                    {out_uuid, out_wid, out_PC, out_op_type, out_rd, out_wb} !== e.tags ||
                    (e.tmask[0] && (out_addr[0] !== e.addr[0] || out_store_data[0] !== e.data[0])) ||
                    (e.tmask[1] && (out_addr[1] !== e.addr[1] || out_store_data[1] !== e.data[1]))) begin
                    n_fail++; $display("FAIL rand_batch cyc%0d: got idx/tm/sop/eop %b addr %h expected %b addr %h",
                                       cyc, {out_batch_idx, out_tmask, out_sop, out_eop}, out_addr, {e.idx, e.tmask, e.sop, e.eop}, e.addr);
                end
                if (out_ready) void'(exp_q.pop_front());
            end
            if (in_valid && exp_ready) begin
                model_push(reqs[sent]);
                sent++;
            end
        end
        n_tests++;
        if (cyc >= 5000) begin n_fail++; $display("FAIL rand_timeout: got %0d of %0d requests sent, %0d batches pending", sent, nreq, exp_q.size()); end
        @(negedge clk); in_valid = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        in_valid      = 1'b0;
        out_ready     = 1'b0;
        in_uuid       = '0;
        in_wid        = '0;
        in_PC         = '0;
        in_op_type    = '0;
        in_rd         = '0;
        in_wb         = 1'b0;
        in_tmask      = '0;
        in_store_data = '0;
        in_base_addr  = '0;
        in_offset     = '0;
        test_reset();
        test_two_batches();
        test_single_batch();
        test_empty_mask();
        test_stall_wrap();
        test_back_to_back();
        test_reset_mid();
        test_random(200);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
